sram_32x4096_1rw: RTL and testbench



---
 rtl/sram_pkg.sv | 17 +
 rtl/sram_bitcell_array.sv | 46 ++++
 rtl/sram_32x4096_1rw.sv | 73 +++++++
 tb/tb_sram_32x4096_1rw.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// sram_pkg: shared constants and types for the single-port SRAM model.
//   SRAM_DATA_WIDTH         : word width (32 bits)
//   SRAM_DEFAULT_ADDR_WIDTH : default address width (12 -> 4096 words)
//   sram_word_t             : one 32-bit storage word
//   sram_depth()            : number of words for a given address width
package sram_pkg;

  localparam int SRAM_DATA_WIDTH         = 32;
  localparam int SRAM_DEFAULT_ADDR_WIDTH = 12;

  typedef logic [SRAM_DATA_WIDTH-1:0] sram_word_t;

  function automatic int sram_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/sram_bitcell_array.sv
// sram_bitcell_array: storage array with one write port and one registered
// read port, sharing a single address.
// Ports:
//   clk   : clock, all updates on the rising edge
//   clr   : synchronous clear of the read register (array untouched)
//   we    : full-word write enable (active high, already qualified)
//   re    : read enable (active high, already qualified)
//   addr  : word address
//   din   : write data
//   rdata : registered read data; holds when re is low
module sram_bitcell_array
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = sram_depth(ADDR_WIDTH);

  // Power-up contents are all zero; reset never clears the array.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

  // A write cycle leaves rdata alone: there is no write-through path.
  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sram_32x4096_1rw.sv
// sram_32x4096_1rw: behavioural single-port (1RW) synchronous SRAM,
// 32-bit words, 2**ADDR_WIDTH_in deep (4096 by default).
// Ports:
//   clk0  : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset; clears dout0, suppresses the access
//           presented in that cycle, leaves the array contents intact
//   csb0  : chip select, active low
//   web0  : write enable, active low (full-word write)
//   addr0 : word address
//   din0  : write data
//   dout0 : read data, read latency 1 (2 with SRAM_DOUT_REG_EN)
// Optional build macro:
//   SRAM_DOUT_REG_EN : adds an output pipeline register (latency 2).
module sram_32x4096_1rw
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH_in = SRAM_DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH    = SRAM_DATA_WIDTH
) (
  input  logic                     clk0,
  input  logic                     rst_n,
  input  logic                     csb0,
  input  logic                     web0,
  input  logic [ADDR_WIDTH_in-1:0] addr0,
  input  logic [DATA_WIDTH-1:0]    din0,
  output logic [DATA_WIDTH-1:0]    dout0
);

  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;

  // Accesses are gated by rst_n so a reset cycle never touches the array.
  assign wr_en = rst_n & ~csb0 & ~web0;
  assign rd_en = rst_n & ~csb0 &  web0;

  sram_bitcell_array #(
    .ADDR_WIDTH (ADDR_WIDTH_in),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk   (clk0),
    .clr   (~rst_n),
    .we    (wr_en),
    .re    (rd_en),
    .addr  (addr0),
    .din   (din0),
    .rdata (rd_data)
  );

`ifdef SRAM_DOUT_REG_EN
  // Second stage follows the read register every cycle.
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else begin
      dout_q <= rd_data;
    end
  end

  assign dout0 = dout_q;
`else
  assign dout0 = rd_data;
`endif

`ifndef SYNTHESIS
  // Unknown control while out of reset would make the access ambiguous.
  a_ctrl_known: assert property (@(posedge clk0) disable iff (!rst_n)
    !$isunknown({csb0, web0}));
`endif

endmodule

// File: tb/tb_sram_32x4096_1rw.sv
// tb_sram_32x4096_1rw: randomized and directed stimulus against a behavioural
// memory model; one compare process checks dout0 on every falling edge.
module tb_sram_32x4096_1rw;
  import sram_pkg::*;

`ifdef SRAM_DOUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic          clk0 = 1'b0;
  logic          rst_n;
  logic          csb0;
  logic          web0;
  logic [AW-1:0] addr0;
  sram_word_t    din0;
  sram_word_t    dout0;

  always #5 clk0 = ~clk0;

  sram_32x4096_1rw dut (
    .clk0  (clk0),
    .rst_n (rst_n),
    .csb0  (csb0),
    .web0  (web0),
    .addr0 (addr0),
    .din0  (din0),
    .dout0 (dout0)
  );

  // ---------------- reference model ----------------
  sram_word_t model_mem [DEPTH];
  sram_word_t s1;       // data the first read stage must hold
  sram_word_t s2;       // data the optional output stage must hold
  sram_word_t exp_out;

  // literal expectations pinning both DUT and model
  logic       lit_req;
  sram_word_t lit_val;
  string      lit_name;
  logic       check_en;

  int total = 0;
  int bad   = 0;

  // Apply one cycle's inputs, advance the model at the edge, return at the
  // following falling edge where the compare process samples.
  task automatic cycle(input logic r, input logic c, input logic w,
                       input logic [AW-1:0] a, input sram_word_t d,
                       input logic chk, input sram_word_t lv, input string nm);
    sram_word_t n1, n2;
    rst_n = r; csb0 = c; web0 = w; addr0 = a; din0 = d;
    @(posedge clk0);
    n2 = r ? s1 : '0;
    if (!r)           n1 = '0;
    else if (!c && w) n1 = model_mem[a];
    else              n1 = s1;
    if (r && !c && !w) model_mem[a] = d;
    s1 = n1;
    s2 = n2;
    exp_out  = (LAT == 2) ? s2 : s1;
    lit_req  = chk;
    lit_val  = lv;
    lit_name = nm;
    @(negedge clk0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input sram_word_t d);
    cycle(1'b1, 1'b0, 1'b0, a, d, 1'b0, '0, "");
  endtask

  task automatic do_idle(input logic chk, input sram_word_t lv, input string nm);
    cycle(1'b1, 1'b1, 1'b1, '0, '0, chk, lv, nm);
  endtask

  // Read and check the literal once the latency has elapsed.
  task automatic read_lit(input logic [AW-1:0] a, input sram_word_t lv, input string nm);
    if (LAT == 1) begin
      cycle(1'b1, 1'b0, 1'b1, a, '0, 1'b1, lv, nm);
    end else begin
      cycle(1'b1, 1'b0, 1'b1, a, '0, 1'b0, '0, "");
      do_idle(1'b1, lv, nm);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk0) begin
    if (check_en) begin
      total++;
      if (dout0 !== exp_out) begin
        bad++;
        $display("FAIL model_cmp t=%0t dout0=%h expected=%h", $time, dout0, exp_out);
      end
      if (lit_req) begin
        total++;
        if (dout0 !== lit_val) begin
          bad++;
          $display("FAIL %s dout0=%h expected=%h", lit_name, dout0, lit_val);
        end
        total++;
        if (exp_out !== lit_val) begin
          bad++;
          $display("FAIL %s_model model=%h expected=%h", lit_name, exp_out, lit_val);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] ra;
    logic          rr, rc, rw;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    s1 = '0; s2 = '0; exp_out = '0;
    lit_req = 1'b0; lit_val = '0; lit_name = "";
    rst_n = 1'b0; csb0 = 1'b1; web0 = 1'b1; addr0 = '0; din0 = '0;
    check_en = 1'b0;
    @(negedge clk0);
    check_en = 1'b1;

    // reset with a write presented: write must be ignored
    cycle(1'b0, 1'b0, 1'b0, 12'd5, 32'hDEADBEEF, 1'b1, 32'h0, "reset_dout");
    cycle(1'b0, 1'b0, 1'b0, 12'd5, 32'hDEADBEEF, 1'b1, 32'h0, "reset_dout2");
    read_lit(12'd5, 32'h0, "reset_write_suppressed");

    // boundary addresses
    do_write(12'd0,    32'hA5A5_0001);
    do_write(12'd4095, 32'h1234_5678);
    read_lit(12'd0,    32'hA5A5_0001, "rd_addr0");
    read_lit(12'd4095, 32'h1234_5678, "rd_addr4095");

    // deselect: no write, output holds
    cycle(1'b1, 1'b1, 1'b0, 12'd7, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678, "deselect_hold");
    read_lit(12'd7, 32'h0, "deselect_no_write");

    // write does not disturb dout0
    read_lit(12'd0, 32'hA5A5_0001, "pre_write_read");
    cycle(1'b1, 1'b0, 1'b0, 12'd0, 32'hCAFE_BABE, 1'b1, 32'hA5A5_0001, "no_write_through");
    read_lit(12'd0, 32'hCAFE_BABE, "read_after_write");

    // pipelined reads
    for (int i = 0; i < 16; i++) do_write(AW'(i), 32'h0101_0101 * i);
    for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0, 1'b1, AW'(i), '0, 1'b0, '0, "");
    read_lit(12'd15, 32'h0F0F_0F0F, "pipe_last");

    // reset in the middle of a read stream
    for (int i = 0; i < 8; i++) begin
      if (i == 4) cycle(1'b0, 1'b0, 1'b1, AW'(i), '0, 1'b1, 32'h0, "mid_reset");
      else        cycle(1'b1, 1'b0, 1'b1, AW'(i), '0, 1'b0, '0, "");
    end
    read_lit(12'd3, 32'h0303_0303, "after_mid_reset");

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0:       ra = '0;
        1:       ra = AW'(DEPTH - 1 - $urandom_range(0, 1));
        2:       ra = AW'($urandom_range(0, 15));
        default: ra = AW'($urandom_range(0, DEPTH - 1));
      endcase
      rr = ($urandom_range(0, 31) != 0);
      rc = ($urandom_range(0, 3) == 0);
      rw = $urandom_range(0, 1) == 1;
      cycle(rr, rc, rw, ra, $urandom, 1'b0, '0, "");
    end
    for (int i = 0; i < LAT; i++) do_idle(1'b0, '0, "");

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
